// File: rtl/module_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one shift/add-3 step per clock).
// Accepts a two's-complement or unsigned word on start and reports sign plus packed BCD digits.
module module_bin2bcd_seq #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIGITS    = 3,
    parameter bit          SIGNED_IN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    if ((64'd10 ** DIGITS) < (64'd1 << WIDTH)) begin : g_range_check
        $error("module_bin2bcd_seq: DIGITS too small to represent 2**WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic [BcdW-1:0]     scratch_q, scratch_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                neg_int_q, neg_int_d;
    logic [BcdW-1:0]     bcd_q, bcd_d;
    logic                neg_q, neg_d;

    logic [BcdW-1:0]       adj;
    logic [BcdW+WIDTH-1:0] shifted;
    logic                  in_neg;
    logic [WIDTH-1:0]      in_mag;

    // Add-3 correction uses the pre-shift digit values, all digits in parallel.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {adj, mag_q} << 1;

    // WIDTH-bit negate is exact for the most negative input: it maps to 2**(WIDTH-1) unsigned.
    assign in_neg = SIGNED_IN && bin[WIDTH-1];
    assign in_mag = in_neg ? (~bin + 1'b1) : bin;

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        neg_int_d = neg_int_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d   = StConv;
                    mag_d     = in_mag;
                    neg_int_d = in_neg;
                    scratch_d = '0;
                    cnt_d     = '0;
                end
            end
            StConv: begin
                scratch_d = shifted[BcdW+WIDTH-1:WIDTH];
                mag_d     = shifted[WIDTH-1:0];
                cnt_d     = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    bcd_d   = shifted[BcdW+WIDTH-1:WIDTH];
                    neg_d   = neg_int_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            neg_int_q <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            neg_int_q <= neg_int_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
        end
    end

    assign busy = (state_q == StConv);
    assign done = (state_q == StDone);
    assign bcd  = bcd_q;
    assign neg  = neg_q;

endmodule

// File: doc/module_bin2bcd_seq.md
Name: module_bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter that sits directly downstream of the Booth multiplier.
- Takes the multiplier's 8-bit two's-complement product on a start pulse and produces a sign flag plus three packed BCD digits for the display/scan stage.
- Uses iterative double-dabble: one shift/add-3 step per clock, with a start/busy/done handshake.

Parameters:
- WIDTH, 8, binary input width in bits.
- DIGITS, 3, number of BCD output digits; 10^DIGITS must be ≥ 2^WIDTH (checked at elaboration).
- SIGNED_IN, 1, 1 = input is two's complement (magnitude converted, neg flag set); 0 = input is unsigned.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  conversion request, sampled only in IDLE
- bin  input  WIDTH  binary value, captured on the accepting edge only
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: bcd/neg are updated this cycle
- neg  output  1  sign of last converted value (0 when SIGNED_IN=0)
- bcd  output  4*DIGITS  packed digits, [3:0] = units, [7:4] = tens, [11:8] = hundreds

Behaviour:
- Reset, synchronous on a clk edge with rst=1:
  - state=IDLE; busy=0, done=0, neg=0, bcd=0.
  - Internal shift register and iteration counter are cleared.
  - rst takes priority over start and over any in-flight conversion.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - Edge k with start=1: latch mag and neg_int, clear the scratch BCD register, cnt=0, go to CONV. busy=1 from the cycle after edge k.
  - SIGNED_IN=1 and bin[WIDTH-1]=1: mag = -bin computed in WIDTH+1 bits, so -128 gives mag 128 without overflow; neg_int=1.
  - Otherwise: mag = bin, neg_int=0.
  - start=0: stay in IDLE, outputs held.
- CONV:
  - Each edge performs one double-dabble iteration:
    - Every scratch BCD digit ≥5 gets +3 (all digits corrected in parallel, using pre-shift values).
    - {scratch, mag} is then shifted left by 1.
  - cnt increments each iteration. After exactly WIDTH iterations (edges k+1 … k+WIDTH), go to DONE.
  - The result of the final iteration is written into the bcd output register on edge k+WIDTH, and neg <= neg_int on the same edge.
- DONE:
  - Lasts one cycle: done=1, busy=0.
  - Next edge returns to IDLE, done=0.
  - start=1 during the DONE cycle is accepted as a new request; behaviour is identical to IDLE acceptance (back-to-back conversions allowed).
- Latency: start sampled at edge k → done visible in the cycle after edge k+WIDTH (8 cycles for defaults). Throughput is one conversion per WIDTH+1 cycles.
- start while busy=1 is ignored; no queuing. bin changes during CONV have no effect.
- bcd and neg hold the last result until the next done; they never show intermediate values.
- Every digit of bcd is always in 0–9.
- Reset mid-CONV: conversion is abandoned, outputs go to reset values, no done pulse.

Test Plan:
- Reset, then start with bin=8'h00 → done exactly 8 cycles after the start edge; bcd=12'h000, neg=0, busy high for 8 cycles.
- bin=8'hC8 (−56, product 7×−8), SIGNED_IN=1 → bcd=12'h056, neg=1; bin=8'h31 (49) → bcd=12'h049, neg=0.
- Boundaries, SIGNED_IN=1: bin=8'h80 → bcd=12'h128, neg=1; bin=8'h7F → 12'h127, neg=0. With SIGNED_IN=0: bin=8'hFF → 12'h255, neg=0.
- start pulsed again on cycles 3 and 5 of a conversion of 8'h40, with bin changed to 8'h01 → ignored; result 12'h064 with a single done pulse.
- rst asserted at cycle 4 of a conversion → next cycle busy=0, done=0, bcd=0, neg=0; no done pulse afterwards until a new start.
- start held high continuously with bin=8'h0A then 8'hF6 → two conversions 9 cycles apart: 12'h010/neg=0, then 12'h010/neg=1.
